fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the decoder; supplies the 32-bit insn word the decoder consumes, plus its PC.
- Holds the PC and issues sequential word requests to instruction memory. Memory responses come back in order.
- Buffers responses in a small FIFO and hands them downstream with a valid/ready handshake.
- Execute can redirect the PC (branch/jump); in-flight responses are then discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, FIFO entries = max outstanding + buffered words (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word address of request, [1:0]=00
- imem_rsp_valid  in  1  response word valid (no backpressure; in order)
- imem_rsp_data  in  32  response instruction word
- redirect  in  1  load new PC, flush
- redirect_pc  in  32  redirect target
- out_valid  out  1  out_insn/out_pc valid to decoder
- out_ready  in  1  decoder accepts
- out_insn  out  32  instruction word
- out_pc  out  32  PC of out_insn
- out_fault  out  1  misaligned-target fault (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge) loads:
  - pc=RESET_PC, head_pc=RESET_PC
  - inflight=0, drop_cnt=0, FIFO empty
- Reset output values:
  - imem_req_valid, out_valid and out_fault read 0 while rst=1 and in the first cycle after.
  - out_insn and out_pc read 0 while the FIFO is empty.
- Reset mid-operation discards everything. Responses for requests issued before reset are ignored: drop_cnt is not preserved across reset, so the memory must be reset with this unit.
- Request issue:
  - imem_req_valid = !rst && !redirect && (inflight + fifo_count < DEPTH).
  - imem_addr = pc.
  - On a handshake: pc += 4 (wraps modulo 2^32), inflight += 1.
  - imem_addr stays stable while valid && !ready.
  - A redirect may withdraw an un-accepted request; the memory must tolerate this.
- Response handling:
  - If drop_cnt > 0: the word is discarded, drop_cnt -= 1.
  - Otherwise the word is pushed into the FIFO.
  - Either way inflight -= 1.
  - An issue and a response in the same cycle leave inflight unchanged.
- Credit rule: the FIFO can never overflow. A push and a pop in the same cycle at full are legal.
- Output:
  - out_valid = FIFO non-empty && !redirect.
  - out_insn = FIFO head; out_pc = head_pc.
  - A pop happens on out_valid && out_ready; head_pc += 4.
  - out_insn and out_pc hold stable while out_valid && !out_ready.
- Latency:
  - Request accepted at cycle t, response at t+L, out_valid at t+L+1 (registered FIFO, no bypass).
  - After reset, the first request is issued in cycle 1.
- Redirect (cycle N) takes priority over all other events in that cycle:
  - pc and head_pc <= redirect_pc; FIFO cleared.
  - No request issued and no pop occurs.
  - drop_cnt <= drop_cnt + inflight - (imem_rsp_valid ? 1 : 0). A response arriving in cycle N is itself discarded.
  - First request for the new target is issued in cycle N+1.
- Back-to-back redirects: each one reloads the PC; drop counting stays exact.
- Throughput: one insn per cycle when memory is single-cycle (L=1) and DEPTH>=2.

Optional Feature:
- Macro FETCH_MISALIGN_EN.
- Defined: a redirect with redirect_pc[1:0] != 00 enters FAULT state.
  - No requests are issued; the FIFO stays empty of words.
  - out_valid=1, out_fault=1, out_insn=0, out_pc=redirect_pc, until the next redirect or reset.
  - Accepting the fault beat (out_ready) does not clear it.
- Not defined: redirect_pc[1:0] is forced to 00 and out_fault is tied 0.

Test Plan:
- Reset, RESET_PC=0x100, 1-cycle memory, out_ready=1 -> requests to 0x100, 0x104, 0x108...; out_pc 0x100 first valid 2 cycles after first request; then one insn per cycle.
- out_ready=0 for 5 cycles -> requests stop once inflight+count=2; out_insn/out_pc held; on release, no word lost or duplicated.
- 3-cycle latency memory, redirect to 0x200 with 2 requests outstanding -> both stale responses dropped; next out_pc=0x200 with the word fetched from 0x200.
- Redirect in the same cycle as a response and a decoder pop -> response discarded, no pop, out_valid=0 that cycle, following outputs start at target.
- imem_req_ready toggling 0/1 -> imem_addr stable while stalled; sequence contiguous; pc wraps 0xFFFF_FFFC -> 0x0000_0000.
- With FETCH_MISALIGN_EN, redirect to 0x202 -> out_valid=1, out_fault=1, out_pc=0x202, no imem requests; later redirect to 0x300 -> normal fetch at 0x300 and out_fault=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channel plus the decoder-facing beat.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_insn, out_pc, out_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_insn, out_pc, out_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word requests, in-order response FIFO, redirect flush.
// Define FETCH_MISALIGN_EN to turn misaligned redirect targets into a sticky fault beat.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Stale responses from several redirects can overlap new requests, so the drop counter gets headroom.
    localparam int DW = AW + 4;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t        state_q, state_d;
    logic          started;
    logic [31:0]   pc, head_pc;
    logic [CW-1:0] inflight, fifo_count;
    logic [DW-1:0] drop_cnt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   fifo_mem [DEPTH];

    logic [31:0]   target_pc;
    logic          target_bad;
    logic          in_fault, fifo_empty, req_ok, out_ok, issue, push, pop;
    logic [CW:0]   used;

`ifdef FETCH_MISALIGN_EN
    assign target_pc  = bus.redirect_pc;
    assign target_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign target_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    always_comb begin
        in_fault   = (state_q == ST_FAULT);
        fifo_empty = (fifo_count == '0);
        used       = {1'b0, inflight} + {1'b0, fifo_count};
        req_ok     = started && !rst && !bus.redirect && !in_fault && (used < CREDIT);
        out_ok     = !rst && !bus.redirect && (in_fault || !fifo_empty);
        issue      = req_ok && bus.imem_req_ready;
        push       = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect && !in_fault;
        pop        = out_ok && bus.out_ready && !in_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = target_bad ? ST_FAULT : ST_RUN;
        end
    end

    always_comb begin
        bus.imem_req_valid = req_ok;
        bus.imem_addr      = pc;
        bus.out_valid      = out_ok;
        bus.out_fault      = out_ok && in_fault;
        bus.out_insn       = '0;
        bus.out_pc         = '0;
        if (in_fault) begin
            bus.out_pc = head_pc;
        end else if (!fifo_empty) begin
            bus.out_insn = fifo_mem[rd_ptr];
            bus.out_pc   = head_pc;
        end
    end

    // On redirect the live in-flight count is handed to drop_cnt; a response landing in that same cycle is one of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            started    <= 1'b0;
            pc         <= RESET_PC;
            head_pc    <= RESET_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            started <= 1'b1;
            if (bus.redirect) begin
                pc         <= target_pc;
                head_pc    <= target_pc;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                inflight   <= '0;
                drop_cnt   <= drop_cnt + DW'(inflight) - DW'(bus.imem_rsp_valid);
            end else begin
                if (issue) begin
                    pc <= pc + 32'd4;
                end
                if (pop) begin
                    head_pc <= head_pc + 32'd4;
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - DW'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                inflight   <= inflight + CW'(issue) - CW'(push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, and a randomized
// run against a queue-based reference model. Fault expectations follow FETCH_MISALIGN_EN.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct {
        bit rst; bit ordy; bit redir; logic [31:0] rpc;
        bit e_req; logic [31:0] e_addr; bit e_ov; logic [31:0] e_pc;
    } vec_t;

    rsp_t        mem_q[$];
    int          mem_lat = 1;
    int          cyc = 0;

    req_t        m_req_q[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_fault_pc = '0;
    bit          m_fault = 1'b0;
    bit          m_started = 1'b0;

    bit          t_rst, t_redir, t_rdy, t_ordy, t_rsp;
    logic [31:0] t_rpc;
    bit          e_req, e_ov, e_fault;
    logic [31:0] e_addr, e_pc, e_insn;
    logic        s_req, s_ov, s_fault;
    logic [31:0] s_addr, s_pc, s_insn;

    bit          checking_on = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_output();
        int live;
        live = 0;
        foreach (m_req_q[i]) if (!m_req_q[i].stale) live++;
        e_req   = !t_rst && m_started && !t_redir && !m_fault && (live + m_fifo.size() < DEPTH);
        e_addr  = m_pc;
        e_ov    = !t_rst && !t_redir && (m_fault || m_fifo.size() > 0);
        e_fault = !t_rst && !t_redir && m_fault;
        if (m_fault) begin
            e_pc = m_fault_pc; e_insn = '0;
        end else if (m_fifo.size() > 0) begin
            e_pc = m_fifo[0]; e_insn = memfn(m_fifo[0]);
        end else begin
            e_pc = '0; e_insn = '0;
        end
        s_req = bus.imem_req_valid; s_addr = bus.imem_addr;
        s_ov = bus.out_valid; s_pc = bus.out_pc; s_insn = bus.out_insn; s_fault = bus.out_fault;
        if (checking_on) begin
            check("req_valid", s_req, e_req);
            if (e_req) check("imem_addr", s_addr, e_addr);
            check("out_valid", s_ov, e_ov);
            check("out_fault", s_fault, e_fault);
            check("out_pc", s_pc, e_pc);
            check("out_insn", s_insn, e_insn);
        end
    endtask

    task automatic update_memory();
        if (t_rsp) void'(mem_q.pop_front());
        if (t_rst) mem_q.delete();
        else if (s_req === 1'b1 && t_rdy) mem_q.push_back('{cyc + mem_lat, memfn(s_addr)});
    endtask

    task automatic update_model();
        req_t        r;
        logic [31:0] tgt;
        bit          mis;
        if (t_rst) begin
            m_req_q.delete(); m_fifo.delete();
            m_pc = RESET_PC; m_started = 1'b0; m_fault = 1'b0;
        end else begin
            m_started = 1'b1;
            if (t_redir) begin
`ifdef FETCH_MISALIGN_EN
                tgt = t_rpc; mis = (t_rpc[1:0] != 2'b00);
`else
                tgt = {t_rpc[31:2], 2'b00}; mis = 1'b0;
`endif
                foreach (m_req_q[i]) m_req_q[i].stale = 1'b1;
                if (t_rsp && m_req_q.size() > 0) void'(m_req_q.pop_front());
                m_fifo.delete();
                m_pc = tgt; m_fault = mis; m_fault_pc = tgt;
            end else begin
                if (e_ov && t_ordy && !m_fault && m_fifo.size() > 0) void'(m_fifo.pop_front());
                if (t_rsp && m_req_q.size() > 0) begin
                    r = m_req_q.pop_front();
                    if (!r.stale) m_fifo.push_back(r.addr);
                end
                if (e_req && t_rdy) begin
                    m_req_q.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit rd, input logic [31:0] rpc,
                                  input bit rdy, input bit ordy);
        @(negedge clk);
        t_rst = r; t_redir = rd; t_rpc = rpc; t_rdy = rdy; t_ordy = ordy;
        t_rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        rst = r;
        bus.redirect = rd; bus.redirect_pc = rpc;
        bus.imem_req_ready = rdy; bus.out_ready = ordy;
        bus.imem_rsp_valid = t_rsp;
        bus.imem_rsp_data = t_rsp ? mem_q[0].data : $urandom;
        #1;
        check_output();
        update_memory();
        update_model();
        cyc++;
    endtask

    task automatic do_reset(input int lat);
        mem_lat = lat;
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic wait_valid(input string name, input int budget, input bit ordy, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b1, ordy);
            n = i + 1;
            if (s_ov === 1'b1) break;
        end
        check({name, "_valid"}, s_ov, 1'b1);
    endtask

    function automatic void add_vec(input bit r, input bit ordy, input bit rd, input logic [31:0] rpc,
                                    input bit er, input logic [31:0] ea, input bit eo, input logic [31:0] ep);
        vecs.push_back('{r, ordy, rd, rpc, er, ea, eo, ep});
    endfunction

    initial begin
        int          n;
        bit          prev_stall, saw_wrap, rdy;
        logic [31:0] prev_addr, last_pc;

        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;

        // One cycle after reset is idle, then the credit limit of 2 shapes the issue pattern.
        add_vec(1, 1, 0, 0,      0, 0,        0, 0);
        add_vec(0, 1, 0, 0,      0, 0,        0, 0);
        add_vec(0, 1, 0, 0,      1, 32'h100,  0, 0);
        add_vec(0, 1, 0, 0,      1, 32'h104,  0, 0);
        add_vec(0, 1, 0, 0,      0, 0,        1, 32'h100);
        add_vec(0, 1, 0, 0,      1, 32'h108,  1, 32'h104);
        add_vec(0, 1, 0, 0,      1, 32'h10C,  0, 0);
        add_vec(0, 1, 0, 0,      0, 0,        1, 32'h108);
        add_vec(0, 1, 0, 0,      1, 32'h110,  1, 32'h10C);
        add_vec(0, 0, 0, 0,      1, 32'h114,  0, 0);
        add_vec(0, 0, 0, 0,      0, 0,        1, 32'h110);
        add_vec(0, 0, 0, 0,      0, 0,        1, 32'h110);
        add_vec(0, 0, 0, 0,      0, 0,        1, 32'h110);
        add_vec(0, 0, 0, 0,      0, 0,        1, 32'h110);
        add_vec(0, 1, 0, 0,      0, 0,        1, 32'h110);
        add_vec(0, 1, 0, 0,      1, 32'h118,  1, 32'h114);
        add_vec(0, 1, 0, 0,      1, 32'h11C,  0, 0);
        add_vec(0, 1, 0, 0,      0, 0,        1, 32'h118);
        add_vec(0, 1, 1, 32'h200, 0, 0,       0, 32'h11C);
        add_vec(0, 1, 0, 0,      1, 32'h200,  0, 0);
        add_vec(0, 1, 0, 0,      1, 32'h204,  0, 0);
        add_vec(0, 1, 0, 0,      0, 0,        1, 32'h200);

        apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        checking_on = 1'b1;
        mem_lat = 1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].redir, vecs[i].rpc, 1'b1, vecs[i].ordy);
            check($sformatf("tbl%0d_req", i), s_req, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("tbl%0d_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("tbl%0d_ov", i), s_ov, vecs[i].e_ov);
            check($sformatf("tbl%0d_pc", i), s_pc, vecs[i].e_pc);
            check($sformatf("tbl%0d_insn", i), s_insn, (vecs[i].e_pc != 0) ? memfn(vecs[i].e_pc) : 32'h0);
        end

        $display("[TB] redirect with two stale responses outstanding");
        do_reset(3);
        repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        wait_valid("redir_drop", 20, 1'b0, n);
        check("redir_drop_lat", n, 5);
        check("redir_drop_pc", s_pc, 32'h200);
        check("redir_drop_insn", s_insn, memfn(32'h200));
        repeat (6) apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        $display("[TB] redirect coinciding with response and pop");
        do_reset(1);
        repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        check("redir_pop_ov", s_ov, 1'b0);
        check("redir_pop_req", s_req, 1'b0);
        wait_valid("redir_pop", 10, 1'b1, n);
        check("redir_pop_pc", s_pc, 32'h300);

        $display("[TB] stalled requests and pc wrap");
        do_reset(2);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
        prev_stall = 1'b0; saw_wrap = 1'b0; prev_addr = '0; last_pc = '0;
        for (int i = 0; i < 40; i++) begin
            rdy = (i % 3) != 0;
            apply_stimulus(1'b0, 1'b0, '0, rdy, 1'b1);
            if (prev_stall) begin
                check("addr_hold", s_addr, prev_addr);
                check("req_hold", s_req, 1'b1);
            end
            prev_stall = (s_req === 1'b1) && !rdy;
            prev_addr  = s_addr;
            if (s_ov === 1'b1) begin
                if (last_pc == 32'hFFFF_FFFC && s_pc == 32'h0) saw_wrap = 1'b1;
                last_pc = s_pc;
            end
        end
        check("pc_wrap", saw_wrap, 1'b1);

        $display("[TB] misaligned redirect target");
        do_reset(1);
        repeat (4) apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h202, 1'b1, 1'b1);
`ifdef FETCH_MISALIGN_EN
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
            check("fault_ov", s_ov, 1'b1);
            check("fault_flag", s_fault, 1'b1);
            check("fault_pc", s_pc, 32'h202);
            check("fault_insn", s_insn, 32'h0);
            check("fault_req", s_req, 1'b0);
        end
`else
        wait_valid("align_force", 10, 1'b1, n);
        check("align_pc", s_pc, 32'h200);
        check("align_fault", s_fault, 1'b0);
`endif
        apply_stimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        wait_valid("fault_exit", 10, 1'b1, n);
        check("fault_exit_pc", s_pc, 32'h300);
        check("fault_exit_flag", s_fault, 1'b0);

        $display("[TB] randomized traffic against reference model");
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            bit          r, rd, rr, ordy;
            logic [31:0] rpc;
            r = ($urandom_range(0, 149) == 0);
            if (r) mem_lat = $urandom_range(1, 3);
            rd = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       begin rpc = $urandom; rpc[1:0] = 2'b00; end
                1:       rpc = 32'hFFFF_FFF8;
                2:       rpc = 32'h400 + ($urandom_range(0, 15) << 2);
                default: rpc = $urandom;
            endcase
            rr   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            apply_stimulus(r, rd, rpc, rr, ordy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
